// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage:
// ALU opcodes, mul/div FSM states and the EX/MEM bundle.
package ex_pkg;

  localparam int MULDIV_CYCLES_DEF = 32;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_XOR   = 6'd4;
  localparam logic [5:0] OP_NOR   = 6'd5;
  localparam logic [5:0] OP_SLT   = 6'd6;
  localparam logic [5:0] OP_SLTU  = 6'd7;
  localparam logic [5:0] OP_SLL   = 6'd8;
  localparam logic [5:0] OP_SRL   = 6'd9;
  localparam logic [5:0] OP_SRA   = 6'd10;
  localparam logic [5:0] OP_LUI   = 6'd11;
  localparam logic [5:0] OP_MULT  = 6'd16;
  localparam logic [5:0] OP_MULTU = 6'd17;
  localparam logic [5:0] OP_DIV   = 6'd18;
  localparam logic [5:0] OP_DIVU  = 6'd19;
  localparam logic [5:0] OP_MFHI  = 6'd20;
  localparam logic [5:0] OP_MFLO  = 6'd21;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  typedef struct packed {
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] alu_result;
    logic [31:0] writedata;
    logic [4:0]  writereg;
  } ex_mem_t;

  function automatic logic is_muldiv(logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider
// working on magnitudes, with sign fixup into HI/LO.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW =
    ($clog2(CYCLES) > 6) ? $clog2(CYCLES) : 6;
  localparam logic [CW-1:0] LAST  = CW'(CYCLES - 1);
  localparam logic [CW-1:0] STEPS = CW'(32);

  md_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic          is_mul, neg, rneg, dz;
  logic [31:0]   mag, dvd;
  logic [63:0]   acc, acc_step, acc_nx;
  logic          sgn, op_mul, sa, sb;
  logic [31:0]   ma, mb;
  logic [32:0]   sum, rsh, diff;
  logic [63:0]   prod;
  logic [31:0]   quo, rem, hi_nx, lo_nx;

  // Operand magnitudes and signs captured at start
  always_comb begin
    op_mul = (op == OP_MULT) || (op == OP_MULTU);
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    sa     = sgn & a[31];
    sb     = sgn & b[31];
    ma     = sa ? -a : a;
    mb     = sb ? -b : b;
  end

  // One multiply or divide iteration on the accumulator
  always_comb begin
    sum  = {1'b0, acc[63:32]} +
           {1'b0, (acc[0] ? mag : 32'h0)};
    rsh  = {acc[63:32], acc[31]};
    diff = rsh - {1'b0, mag};
    if (is_mul)
      acc_step = {sum, acc[31:1]};
    else if (diff[32])
      acc_step = {rsh[31:0], acc[30:0], 1'b0};
    else
      acc_step = {diff[31:0], acc[30:0], 1'b1};
    acc_nx = (cnt < STEPS) ? acc_step : acc;
  end

  // Sign fixup and divide-by-zero result
  always_comb begin
    prod  = neg ? -acc_nx : acc_nx;
    quo   = neg ? -acc_nx[31:0] : acc_nx[31:0];
    rem   = rneg ? -acc_nx[63:32] : acc_nx[63:32];
    hi_nx = rem;
    lo_nx = quo;
    if (is_mul) begin
      hi_nx = prod[63:32];
      lo_nx = prod[31:0];
    end else if (dz) begin
      hi_nx = dvd;
      lo_nx = 32'hFFFF_FFFF;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // Operand latch, iteration datapath and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      mag    <= '0;
      dvd    <= '0;
      is_mul <= 1'b0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE && start) begin
      cnt    <= '0;
      is_mul <= op_mul;
      neg    <= sa ^ sb;
      rneg   <= sa;
      dz     <= (b == 32'h0);
      dvd    <= a;
      mag    <= op_mul ? ma : mb;
      acc    <= {32'h0, (op_mul ? mb : ma)};
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nx;
      if (cnt == LAST) begin
        hi <= hi_nx;
        lo <= lo_nx;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, BEQ resolution, mul/div
// interlock and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        jump,
  input  logic        AluSrc,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic [5:0]  AluOp,
  input  logic [31:0] npc,
  input  logic [31:0] readdata1,
  input  logic [31:0] readdata2,
  input  logic [31:0] sigext,
  input  logic [4:0]  instruction_2015,
  input  logic [4:0]  instruction_1511,
  output logic        stall,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out,
  output logic        jump_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] writedata_out,
  output logic [4:0]  writereg_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  logic [31:0] opa, opb, alu_res;
  logic [4:0]  shamt;
  logic        md_op, md_busy, md_done, md_start;
  ex_mem_t     nxt, ex_mem;

  assign opa   = readdata1;
  assign opb   = AluSrc ? sigext : readdata2;
  assign shamt = sigext[10:6];
  assign md_op = is_muldiv(AluOp);

  // Start only from idle; DONE lets the held op retire
  assign md_start = md_op & ~md_busy & ~md_done;
  assign stall    = rst & (md_start | md_busy);

  muldiv_unit #(
    .CYCLES(MULDIV_CYCLES)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .op   (AluOp),
    .a    (opa),
    .b    (opb),
    .busy (md_busy),
    .done (md_done),
    .hi   (hi_out),
    .lo   (lo_out)
  );

  // Single-cycle ALU; unknown codes fall back to ADD
  always_comb begin
    alu_res = opa + opb;
    unique case (AluOp)
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_NOR:  alu_res = ~(opa | opb);
      OP_SLT:  alu_res = {31'h0,
                 ($signed(opa) < $signed(opb))};
      OP_SLTU: alu_res = {31'h0, (opa < opb)};
      OP_SLL:  alu_res = opb << shamt;
      OP_SRL:  alu_res = opb >> shamt;
      OP_SRA:  alu_res =
                 $unsigned($signed(opb) >>> shamt);
      OP_LUI:  alu_res = {opb[15:0], 16'h0};
      OP_MFHI: alu_res = hi_out;
      OP_MFLO: alu_res = lo_out;
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU: alu_res = '0;
      default: alu_res = opa + opb;
    endcase
  end

  // Next EX/MEM contents; a bubble while stalled
  always_comb begin
    nxt = '0;
    if (!stall) begin
      nxt.jump       = jump;
      nxt.mem_read   = MemRead;
      nxt.mem_write  = MemWrite;
      nxt.reg_write  = RegWrite & ~md_op;
      nxt.mem_to_reg = MemtoReg;
      nxt.br_taken   = branch &
                       (readdata1 == readdata2);
      nxt.br_target  = npc + {sigext[29:0], 2'b00};
      nxt.alu_result = alu_res;
      nxt.writedata  = readdata2;
      nxt.writereg   = RegDst ? instruction_1511
                              : instruction_2015;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst)
    if (!rst) ex_mem <= '0;
    else      ex_mem <= nxt;

  assign branch_taken_out  = ex_mem.br_taken;
  assign branch_target_out = ex_mem.br_target;
  assign jump_out          = ex_mem.jump;
  assign MemRead_out       = ex_mem.mem_read;
  assign MemWrite_out      = ex_mem.mem_write;
  assign RegWrite_out      = ex_mem.reg_write;
  assign MemtoReg_out      = ex_mem.mem_to_reg;
  assign alu_result_out    = ex_mem.alu_result;
  assign writedata_out     = ex_mem.writedata;
  assign writereg_out      = ex_mem.writereg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes
// reference results, monitor pops at each retirement.
module tb_ex_stage;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch = 0, jump = 0, AluSrc = 0;
  logic        MemRead = 0, MemWrite = 0, RegWrite = 0;
  logic        RegDst = 0, MemtoReg = 0;
  logic [5:0]  AluOp = '0;
  logic [31:0] npc = '0, readdata1 = '0;
  logic [31:0] readdata2 = '0, sigext = '0;
  logic [4:0]  instruction_2015 = '0;
  logic [4:0]  instruction_1511 = '0;
  logic        stall, branch_taken_out, jump_out;
  logic        MemRead_out, MemWrite_out;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] branch_target_out, alu_result_out;
  logic [31:0] writedata_out, hi_out, lo_out;
  logic [4:0]  writereg_out;

  typedef struct {
    logic [31:0] alu, wd, tgt, hi, lo;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, jmp, tk, chk_alu;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          vecs = 0;
  int          errs = 0;
  logic        v = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  ex_stage #(.MULDIV_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .branch(branch), .jump(jump), .AluSrc(AluSrc),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .AluOp(AluOp), .npc(npc),
    .readdata1(readdata1), .readdata2(readdata2),
    .sigext(sigext),
    .instruction_2015(instruction_2015),
    .instruction_1511(instruction_1511),
    .stall(stall),
    .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out),
    .jump_out(jump_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out),
    .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out),
    .alu_result_out(alu_result_out),
    .writedata_out(writedata_out),
    .writereg_out(writereg_out),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm,
                      input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(
      input logic [5:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] t;
    t = {{32{b[31]}}, b} >> sh;
    case (op)
      6'd1:  return a - b;
      6'd2:  return a & b;
      6'd3:  return a | b;
      6'd4:  return a ^ b;
      6'd5:  return ~(a | b);
      6'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd7:  return (a < b) ? 32'd1 : 32'd0;
      6'd8:  return b << sh;
      6'd9:  return b >> sh;
      6'd10: return t[31:0];
      6'd11: return b * 32'h10000;
      6'd20: return m_hi;
      6'd21: return m_lo;
      default: return a + b;
    endcase
  endfunction

  task automatic md_ref(input logic [5:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    sa = a;
    sb = b;
    if (op == 6'd16) begin
      p = longint'(sa) * longint'(sb);
      {m_hi, m_lo} = p;
    end else if (op == 6'd17) begin
      u = {32'h0, a} * {32'h0, b};
      {m_hi, m_lo} = u;
    end else if (b == 32'h0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else if (op == 6'd18 && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      m_lo = a;
      m_hi = 32'h0;
    end else if (op == 6'd18) begin
      m_lo = sa / sb;
      m_hi = sa % sb;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endtask

  // ctl = {branch,jump,AluSrc,MemRead,MemWrite,
  //        RegWrite,RegDst,MemtoReg}
  task automatic issue(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] imm,
                       input logic [31:0] pc,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [7:0] ctl);
    exp_t        e;
    logic [31:0] bop;
    logic        md;
    int          n, want;
    {branch, jump, AluSrc, MemRead, MemWrite,
     RegWrite, RegDst, MemtoReg} = ctl;
    AluOp = op; readdata1 = a; readdata2 = b;
    sigext = imm; npc = pc;
    instruction_2015 = rt; instruction_1511 = rd;
    bop = ctl[5] ? imm : b;
    md  = (op >= 6'd16) && (op <= 6'd19);
    e.alu = ref_alu(op, a, bop, imm[10:6]);
    if (md) md_ref(op, a, bop);
    e.chk_alu = !md;
    e.wr  = ctl[1] ? rd : rt;
    e.rw  = ctl[2] & !md;
    e.mr  = ctl[4];
    e.mw  = ctl[3];
    e.m2r = ctl[0];
    e.jmp = ctl[6];
    e.tk  = ctl[7] && (a == b);
    e.tgt = pc + imm * 4;
    e.wd  = b;
    e.hi  = m_hi;
    e.lo  = m_lo;
    q.push_back(e);
    v = 1'b1;
    want = md ? N + 1 : 0;
    n = 0;
    @(negedge clk);
    while (stall) begin
      n++;
      if (n == 3) begin
        chkb("bubble_regwrite", RegWrite_out, 1'b0);
        chk("bubble_alu", alu_result_out, 32'h0);
      end
      if (n > 200) begin
        vecs++; errs++;
        $display("FAIL stall_timeout: got %0d want %0d",
                 n, want);
        break;
      end
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(want));
    @(posedge clk);
    #2;
    v = 1'b0;
  endtask

  // Monitor: a retirement happens on the edge after a
  // non-stalled cycle with a valid instruction presented
  initial forever begin
    @(negedge clk);
    if (v && rst && !stall) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL scoreboard_empty: got retire want none");
      end else begin
        mon_e = q.pop_front();
        if (mon_e.chk_alu)
          chk("alu_result", alu_result_out, mon_e.alu);
        chk("writereg", 32'(writereg_out), 32'(mon_e.wr));
        chkb("RegWrite", RegWrite_out, mon_e.rw);
        chkb("MemRead", MemRead_out, mon_e.mr);
        chkb("MemWrite", MemWrite_out, mon_e.mw);
        chkb("MemtoReg", MemtoReg_out, mon_e.m2r);
        chkb("jump", jump_out, mon_e.jmp);
        chkb("br_taken", branch_taken_out, mon_e.tk);
        chk("br_target", branch_target_out, mon_e.tgt);
        chk("writedata", writedata_out, mon_e.wd);
        chk("hi", hi_out, mon_e.hi);
        chk("lo", lo_out, mon_e.lo);
      end
    end
  end

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    int          r;
    #17;
    chkb("rst_stall", stall, 1'b0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_target", branch_target_out, 32'h0);
    chkb("rst_regwrite", RegWrite_out, 1'b0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #2;

    issue(6'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0,
          5'd9, 5'd5, 8'b0000_0110);
    issue(6'd0, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'h100,
          5'd1, 5'd2, 8'b1000_0000);
    issue(6'd0, 32'd7, 32'd8, 32'hFFFF_FFFE, 32'h100,
          5'd1, 5'd2, 8'b1000_0000);
    issue(6'd16, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0,
          5'd3, 5'd4, 8'b0000_0100);
    issue(6'd17, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0,
          5'd3, 5'd4, 8'b0000_0100);
    issue(6'd18, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0,
          5'd3, 5'd4, 8'b0000_0100);
    issue(6'd19, 32'd9, 32'd0, 32'h0, 32'h0,
          5'd3, 5'd4, 8'b0000_0000);
    issue(6'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
          32'h0, 5'd3, 5'd4, 8'b0000_0000);
    issue(6'd16, 32'h1234_5678, 32'hFFFF_FFFD, 32'h0,
          32'h0, 5'd3, 5'd4, 8'b0000_0100);
    issue(6'd20, 32'h0, 32'h0, 32'h0, 32'h0,
          5'd3, 5'd6, 8'b0000_0110);
    issue(6'd10, 32'h0, 32'h8000_0000, 32'h100, 32'h0,
          5'd3, 5'd7, 8'b0000_0110);

    AluOp = 6'd18; readdata1 = 32'd100;
    readdata2 = 32'd3; AluSrc = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chkb("pre_reset_stall", stall, 1'b1);
    rst = 1'b0;
    #1;
    chkb("abort_stall", stall, 1'b0);
    chk("abort_hi", hi_out, 32'h0);
    chk("abort_lo", lo_out, 32'h0);
    chk("abort_alu", alu_result_out, 32'h0);
    chkb("abort_regwrite", RegWrite_out, 1'b0);
    m_hi = '0;
    m_lo = '0;
    AluOp = 6'd0;
    #3 rst = 1'b1;
    @(posedge clk);
    #2;
    issue(6'd17, 32'd3, 32'd4, 32'h0, 32'h0,
          5'd3, 5'd4, 8'b0000_0100);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 11);
      if (r == 0) op = 6'(16 + $urandom_range(0, 3));
      else if (r == 1) op = 6'($urandom_range(20, 63));
      else if (r == 2) op = 6'($urandom_range(20, 21));
      else op = 6'($urandom_range(0, 11));
      a = rval();
      b = rval();
      if ($urandom_range(0, 3) == 0) b = a;
      issue(op, a, b, rval(), $urandom(),
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)),
            8'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
